// File: rtl/btn_pulse_conditioner_if.sv
// ---------------------------------------------------------------------------
// btn_pulse_conditioner_if
//
// Purpose:
//    Groups the board-facing push-button/switch inputs, the FIFO status flags
//    and the FIFO strobe outputs of btn_pulse_conditioner into one bundle.
//
// Parameters:
//    DATA_W      width of the switch bus and of wr_data
//
// Signals:
//    wr_btn_raw  raw write button (asynchronous, bouncy)
//    rd_btn_raw  raw read button (asynchronous, bouncy)
//    sw_raw      raw slide switches (asynchronous)
//    fifo_full   FIFO full flag
//    fifo_empty  FIFO empty flag
//    wr_en       one-cycle write strobe to the FIFO
//    rd_en       one-cycle read strobe to the FIFO
//    wr_data     switch snapshot, valid in the cycle wr_en=1
//    led_err     sticky refused-request indicator
//
// Modports:
//    master      the environment side: drives buttons, switches and flags
//    slave       the conditioner side: consumes them and drives the strobes
// ---------------------------------------------------------------------------
interface btn_pulse_conditioner_if #(
    parameter int DATA_W = 8
);
    logic              wr_btn_raw;
    logic              rd_btn_raw;
    logic [DATA_W-1:0] sw_raw;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wr_data;
    logic              led_err;

    modport master (
        output wr_btn_raw, rd_btn_raw, sw_raw, fifo_full, fifo_empty,
        input  wr_en, rd_en, wr_data, led_err
    );

    modport slave (
        input  wr_btn_raw, rd_btn_raw, sw_raw, fifo_full, fifo_empty,
        output wr_en, rd_en, wr_data, led_err
    );
endinterface

// File: rtl/btn_pulse_conditioner.sv
// ---------------------------------------------------------------------------
// btn_pulse_conditioner
//
// Purpose:
//    Front-end for top_fifo. Synchronises and debounces the write/read push
//    buttons and the slide switches, turns each debounced press into a single
//    registered one-cycle strobe, gates the strobes against FIFO full/empty
//    and raises a sticky error LED whenever a request has to be refused.
//
// Build option:
//    AUTO_REPEAT_EN  when defined, a held button produces extra requests:
//                    the first REPEAT_DELAY cycles after the press is
//                    accepted, then one every REPEAT_PERIOD cycles until
//                    release. When undefined no repeat logic exists.
//
// Ports:
//    clk_50mhz   in   system clock
//    rst_btn     in   synchronous, active-high reset
//    bus         slave modport of btn_pulse_conditioner_if carrying the raw
//                buttons/switches, the FIFO flags, wr_en/rd_en/wr_data and
//                led_err
//
// Sub-module BtnDebounceChannel (same file): one press/release debounce FSM
// per button, producing a combinational request pulse.
// ---------------------------------------------------------------------------
module BtnDebounceChannel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 25,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sync,
    output logic o_req
);
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } chanState_t;

    chanState_t       r_state;
    chanState_t       w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic             w_pressReq;

    // State and debounce counter registers; reset drops any press in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Next-state logic. The counter starts at 1 on entering a wait state and
    // stops at DEBOUNCE_CYCLES, so it can never wrap. The press request is
    // raised on the same cycle the FSM commits to PRESSED so the strobe can be
    // registered on that very edge. Bouncing back from RELEASE_WAIT into
    // PRESSED is treated as the same press and issues nothing.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_pressReq  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_sync) begin
                    w_nextState = PRESS_WAIT;
                    w_nextCnt   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!i_sync) begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    w_nextState = PRESSED;
                    w_nextCnt   = '0;
                    w_pressReq  = 1'b1;
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!i_sync) begin
                    w_nextState = RELEASE_WAIT;
                    w_nextCnt   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (i_sync) begin
                    w_nextState = PRESSED;
                    w_nextCnt   = '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] r_repCnt;
    logic [CNT_W-1:0] w_nextRepCnt;
    logic             w_repReq;

    // Repeat counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_repCnt <= '0;
        end else begin
            r_repCnt <= w_nextRepCnt;
        end
    end

    // The repeat counter sits at 0 outside PRESSED and counts cycles spent
    // holding. Hitting REPEAT_DELAY-1 fires a request on the edge that is
    // REPEAT_DELAY cycles after entry; reloading with
    // REPEAT_DELAY-REPEAT_PERIOD makes every following request land exactly
    // REPEAT_PERIOD cycles later. A release seen this cycle clears it and
    // suppresses any repeat.
    always_comb begin
        w_nextRepCnt = '0;
        w_repReq     = 1'b0;
        if (r_state == PRESSED && i_sync) begin
            if (r_repCnt == CNT_W'(REPEAT_DELAY - 1)) begin
                w_repReq     = 1'b1;
                w_nextRepCnt = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                w_nextRepCnt = r_repCnt + CNT_W'(1);
            end
        end
    end

    assign o_req = w_pressReq | w_repReq;
`else
    assign o_req = w_pressReq;
`endif
endmodule

module btn_pulse_conditioner #(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 25,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input logic                      clk_50mhz,
    input logic                      rst_btn,
    btn_pulse_conditioner_if.slave   bus
);
    logic              r_wrMeta;
    logic              r_wrSync;
    logic              r_rdMeta;
    logic              r_rdSync;
    logic [DATA_W-1:0] r_swMeta;
    logic [DATA_W-1:0] r_swSync;
    logic              w_wrReq;
    logic              w_rdReq;
    logic              w_wrGo;
    logic              w_rdGo;
    logic              w_refused;

    // Two-flop synchronisers for both buttons and every switch bit.
    always_ff @(posedge clk_50mhz) begin
        if (rst_btn) begin
            r_wrMeta <= 1'b0;
            r_wrSync <= 1'b0;
            r_rdMeta <= 1'b0;
            r_rdSync <= 1'b0;
            r_swMeta <= '0;
            r_swSync <= '0;
        end else begin
            r_wrMeta <= bus.wr_btn_raw;
            r_wrSync <= r_wrMeta;
            r_rdMeta <= bus.rd_btn_raw;
            r_rdSync <= r_rdMeta;
            r_swMeta <= bus.sw_raw;
            r_swSync <= r_swMeta;
        end
    end

    BtnDebounceChannel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_wrChannel (
        .i_clk  (clk_50mhz),
        .i_rst  (rst_btn),
        .i_sync (r_wrSync),
        .o_req  (w_wrReq)
    );

    BtnDebounceChannel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_rdChannel (
        .i_clk  (clk_50mhz),
        .i_rst  (rst_btn),
        .i_sync (r_rdSync),
        .o_req  (w_rdReq)
    );

    // Requests are gated with the flags as they stand on the request cycle; a
    // refused request is simply dropped, leaving only the error LED behind.
    assign w_wrGo    = w_wrReq & ~bus.fifo_full;
    assign w_rdGo    = w_rdReq & ~bus.fifo_empty;
    assign w_refused = (w_wrReq & bus.fifo_full) | (w_rdReq & bus.fifo_empty);

    // Registered strobes, switch snapshot and sticky error LED. wr_data only
    // changes on the edge that raises wr_en so the FIFO always sees the value
    // captured with its own strobe.
    always_ff @(posedge clk_50mhz) begin
        if (rst_btn) begin
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.wr_data <= '0;
            bus.led_err <= 1'b0;
        end else begin
            bus.wr_en <= w_wrGo;
            bus.rd_en <= w_rdGo;
            if (w_wrGo) begin
                bus.wr_data <= r_swSync;
            end
            if (w_refused) begin
                bus.led_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_pulse_conditioner
//
// Purpose:
//    Directed, table-driven bench for btn_pulse_conditioner with a short
//    debounce (4 cycles) and short repeat timings (delay 10, period 3).
//    Each vector is driven 1 time unit after a rising edge and the outputs
//    are checked 1 time unit after the following rising edge. Honours
//    AUTO_REPEAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_btn_pulse_conditioner;
    localparam int DataW     = 8;
    localparam int Debounce  = 4;
    localparam int CntW      = 8;
    localparam int RepDelay  = 10;
    localparam int RepPeriod = 3;
`ifdef AUTO_REPEAT_EN
    localparam bit AutoRep = 1'b1;
`else
    localparam bit AutoRep = 1'b0;
`endif

    typedef struct {
        string            name;
        logic             rst;
        logic             wr;
        logic             rd;
        logic [DataW-1:0] sw;
        logic             full;
        logic             empty;
        logic             expWrEn;
        logic             expRdEn;
        logic [DataW-1:0] expWrData;
        logic             expLedErr;
    } vector_t;

    logic    clock;
    logic    rstBtn;
    int      vecCount;
    int      missCount;
    vector_t vecTable[$];

    btn_pulse_conditioner_if #(.DATA_W(DataW)) busIf ();

    btn_pulse_conditioner #(
        .DATA_W          (DataW),
        .DEBOUNCE_CYCLES (Debounce),
        .CNT_W           (CntW),
        .REPEAT_DELAY    (RepDelay),
        .REPEAT_PERIOD   (RepPeriod)
    ) dut (
        .clk_50mhz (clock),
        .rst_btn   (rstBtn),
        .bus       (busIf)
    );

    // 100 MHz-style free-running bench clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Appends one cycle's stimulus and the outputs expected after its edge.
    function automatic void addVec(string name, logic rst, logic wr, logic rd,
                                   logic [DataW-1:0] sw, logic full, logic empty,
                                   logic eWr, logic eRd, logic [DataW-1:0] eData,
                                   logic eErr);
        vector_t v;
        v.name      = name;
        v.rst       = rst;
        v.wr        = wr;
        v.rd        = rd;
        v.sw        = sw;
        v.full      = full;
        v.empty     = empty;
        v.expWrEn   = eWr;
        v.expRdEn   = eRd;
        v.expWrData = eData;
        v.expLedErr = eErr;
        vecTable.push_back(v);
    endfunction

    // Drives one vector, then advances to just after the next rising edge.
    task automatic applyStimulus(input vector_t v);
        rstBtn           = v.rst;
        busIf.wr_btn_raw = v.wr;
        busIf.rd_btn_raw = v.rd;
        busIf.sw_raw     = v.sw;
        busIf.fifo_full  = v.full;
        busIf.fifo_empty = v.empty;
        @(posedge clock);
        #1;
    endtask

    // Compares all four outputs against the vector's expectations.
    task automatic checkOutput(input vector_t v, input int idx);
        vecCount++;
        if (busIf.wr_en !== v.expWrEn || busIf.rd_en !== v.expRdEn ||
            busIf.wr_data !== v.expWrData || busIf.led_err !== v.expLedErr) begin
            missCount++;
            $display("[TB] FAIL %s #%0d: got wr_en=%b rd_en=%b wr_data=%h led_err=%b, expected wr_en=%b rd_en=%b wr_data=%h led_err=%b",
                     v.name, idx, busIf.wr_en, busIf.rd_en, busIf.wr_data, busIf.led_err,
                     v.expWrEn, v.expRdEn, v.expWrData, v.expLedErr);
        end
    endtask

    // Main sequence: reset, table of single-press scenarios, then hand-built
    // multi-cycle corner cases around reset and the full flag.
    initial begin
        vector_t    v;
        logic [4:0] bouncePat;
        logic       eWr;
        vecCount  = 0;
        missCount = 0;
        bouncePat = 5'b01101;

        // Clean write press with sw=AA, held 30 cycles then released.
        for (int j = 0; j < 40; j++) begin
            eWr = (j == 6) ||
                  (AutoRep && j >= 16 && j <= 31 && ((j - 16) % RepPeriod) == 0);
            addVec("cleanPress", 1'b0, j < 30, 1'b0, 8'hAA, 1'b0, 1'b0,
                   eWr, 1'b0, (j >= 6) ? 8'hAA : 8'h00, 1'b0);
        end
        // Bounce 1,0,1,1,0 then low: no strobe, wr_data keeps AA.
        for (int j = 0; j < 15; j++) begin
            addVec("bounce", 1'b0, (j < 5) ? bouncePat[j] : 1'b0, 1'b0, 8'h55,
                   1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0);
        end
        // Simultaneous wr and rd press with sw=3C, both flags clear.
        for (int j = 0; j < 15; j++) begin
            addVec("simultaneous", 1'b0, j < 8, j < 8, 8'h3C, 1'b0, 1'b0,
                   j == 6, j == 6, (j >= 6) ? 8'h3C : 8'hAA, 1'b0);
        end
        // Read press while empty: no rd_en, sticky led_err from the request.
        for (int j = 0; j < 16; j++) begin
            addVec("readGate", 1'b0, 1'b0, j < 8, 8'h3C, 1'b0, 1'b1,
                   1'b0, 1'b0, 8'h3C, j >= 6);
        end

        // Initial reset pulse.
        v = '{name:"reset", rst:1'b1, wr:1'b0, rd:1'b0, sw:8'h00, full:1'b0,
              empty:1'b0, expWrEn:1'b0, expRdEn:1'b0, expWrData:8'h00, expLedErr:1'b0};
        applyStimulus(v);
        checkOutput(v, 0);

        for (int i = 0; i < vecTable.size(); i++) begin
            applyStimulus(vecTable[i]);
            checkOutput(vecTable[i], i);
        end

        // Reset clears the sticky LED and the held switch snapshot.
        v = '{name:"resetClearsErr", rst:1'b1, wr:1'b0, rd:1'b0, sw:8'h00, full:1'b0,
              empty:1'b0, expWrEn:1'b0, expRdEn:1'b0, expWrData:8'h00, expLedErr:1'b0};
        applyStimulus(v);
        checkOutput(v, 0);

        // Reset in the middle of a debounce discards the pending press.
        for (int j = 0; j < 15; j++) begin
            v = '{name:"resetMidPress", rst:(j == 4), wr:(j < 4), rd:1'b0, sw:8'h11,
                  full:1'b0, empty:1'b0, expWrEn:1'b0, expRdEn:1'b0,
                  expWrData:8'h00, expLedErr:1'b0};
            applyStimulus(v);
            checkOutput(v, j);
        end

        // Write while full is refused, wr_data untouched, LED set.
        for (int j = 0; j < 16; j++) begin
            v = '{name:"writeFull", rst:1'b0, wr:(j < 8), rd:1'b0, sw:8'hC3,
                  full:1'b1, empty:1'b0, expWrEn:1'b0, expRdEn:1'b0,
                  expWrData:8'h00, expLedErr:(j >= 6)};
            applyStimulus(v);
            checkOutput(v, j);
        end

        // A later accepted read still strobes while the LED stays lit.
        for (int j = 0; j < 14; j++) begin
            v = '{name:"readAfterErr", rst:1'b0, wr:1'b0, rd:(j < 8), sw:8'hC3,
                  full:1'b1, empty:1'b0, expWrEn:1'b0, expRdEn:(j == 6),
                  expWrData:8'h00, expLedErr:1'b1};
            applyStimulus(v);
            checkOutput(v, j);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
